scm_write_port_arbiter: RTL and testbench

Write-port controller for the multi-way latch-based register file (SCM). Shares the SCM's single write port among `N_REQ` requesters with round-robin arbitration. Drives the SCM's way, enable, address and data inputs so that the latch array's timing constraints always hold. Optionally sequences a whole-array flush. Sits between refill/update agents and the SCM's write port; read ports are not touched.

---
 rtl/scm_ctrl_pkg.sv | 24 ++
 rtl/scm_rr_arb.sv | 47 ++++
 rtl/scm_write_port_arbiter.sv | 163 ++++++++++++++++
 tb/tb_scm_write_port_arbiter.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scm_ctrl_pkg.sv
// Shared types and helpers for the SCM write-port controller: flush FSM states,
// the write request record and the round-robin pointer step.
package scm_ctrl_pkg;

  localparam int SCM_NB_WAYS = 4;
  localparam int SCM_WADDR_W = 5;
  localparam int SCM_WDATA_W = 64;

  typedef enum logic [0:0] {
    FLUSH_IDLE   = 1'b0,
    FLUSH_ACTIVE = 1'b1
  } scm_flush_state_e;

  typedef struct packed {
    logic [SCM_WADDR_W-1:0] addr;
    logic [SCM_NB_WAYS-1:0] way;
    logic [SCM_WDATA_W-1:0] data;
  } scm_wreq_t;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/scm_rr_arb.sv
// Round-robin arbiter: one-hot grant to the first unmasked request at or after
// the pointer; the pointer moves past the winner whenever a grant is given.
module scm_rr_arb
  import scm_ctrl_pkg::*;
#(
  parameter int N_REQ = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] mask,
  output logic [N_REQ-1:0] gnt
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PTR_W-1:0] ptr;
  logic [N_REQ-1:0] elig;
  logic             found;
  int               win;

  assign elig = req & ~mask;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    win   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!found && elig[i] && (i == (int'(ptr) + k) % N_REQ)) begin
          gnt[i] = 1'b1;
          found  = 1'b1;
          win    = i;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= PTR_W'(rr_next(win, N_REQ));
    end
  end

endmodule

// File: rtl/scm_write_port_arbiter.sv
// Shares the SCM write port among N_REQ requesters, holding WriteWay across the
// latch cycle after each write. Optional whole-array flush under SCM_ARB_FLUSH_EN.
module scm_write_port_arbiter
  import scm_ctrl_pkg::*;
#(
  parameter int NB_WAYS     = 4,
  parameter int WADDR_WIDTH = 5,
  parameter int WDATA_WIDTH = 64,
  parameter int N_REQ       = 3
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [N_REQ-1:0]                      req_valid_i,
  output logic [N_REQ-1:0]                      req_ready_o,
  input  logic [N_REQ-1:0][WADDR_WIDTH-1:0]     req_addr_i,
  input  logic [N_REQ-1:0][NB_WAYS-1:0]         req_way_i,
  input  logic [N_REQ-1:0][WDATA_WIDTH-1:0]     req_data_i,
  output logic                                  scm_we_o,
  output logic [WADDR_WIDTH-1:0]                scm_waddr_o,
  output logic [NB_WAYS-1:0]                    scm_wway_o,
  output logic [WDATA_WIDTH-1:0]                scm_wdata_o,
  output logic                                  commit_valid_o,
  output logic [WADDR_WIDTH-1:0]                commit_addr_o,
  output logic                                  busy_o
`ifdef SCM_ARB_FLUSH_EN
  ,
  input  logic                                  flush_req_i,
  output logic                                  flush_busy_o
`endif
);

  localparam logic [NB_WAYS-1:0] WAY_ALL = '1;

  logic [N_REQ-1:0]       way_haz;
  logic [N_REQ-1:0]       arb_mask;
  logic [N_REQ-1:0]       gnt;
  logic [WADDR_WIDTH-1:0] sel_addr;
  logic [NB_WAYS-1:0]     sel_way;
  logic [WDATA_WIDTH-1:0] sel_data;
  logic                   flush_issue;
  logic                   flush_block;
  logic [WADDR_WIDTH-1:0] flush_addr;
  logic                   flush_busy_next;

  // A write issued now latches next cycle with the way then present, so a
  // different way must wait one cycle.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      way_haz[i] = scm_we_o && (req_way_i[i] != scm_wway_o);
    end
  end

  assign arb_mask    = way_haz | {N_REQ{flush_block}};
  assign req_ready_o = gnt;

  scm_rr_arb #(
    .N_REQ(N_REQ)
  ) u_arb (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req_valid_i),
    .mask (arb_mask),
    .gnt  (gnt)
  );

  always_comb begin
    sel_addr = '0;
    sel_way  = '0;
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        sel_addr = sel_addr | req_addr_i[i];
        sel_way  = sel_way  | req_way_i[i];
        sel_data = sel_data | req_data_i[i];
      end
    end
  end

`ifdef SCM_ARB_FLUSH_EN
  localparam logic [WADDR_WIDTH-1:0] FLUSH_LAST = '1;

  scm_flush_state_e       state;
  logic                   flush_pend;
  logic [WADDR_WIDTH-1:0] flush_cnt;
  logic                   scm_is_flush;
  logic                   flush_want;
  logic                   flush_go;

  assign flush_want      = (state == FLUSH_IDLE) && (flush_req_i || flush_pend);
  assign flush_go        = flush_want && !(scm_we_o && (scm_wway_o != WAY_ALL));
  assign flush_issue     = flush_go || (state == FLUSH_ACTIVE);
  assign flush_block     = flush_want || (state == FLUSH_ACTIVE);
  assign flush_addr      = (state == FLUSH_ACTIVE) ? flush_cnt : '0;
  assign flush_busy_next = flush_issue || scm_is_flush;

  // Address 0 issues on the entering edge; the counter holds the next address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= FLUSH_IDLE;
      flush_pend   <= 1'b0;
      flush_cnt    <= '0;
      scm_is_flush <= 1'b0;
      flush_busy_o <= 1'b0;
    end else begin
      scm_is_flush <= flush_issue;
      flush_busy_o <= flush_busy_next;
      case (state)
        FLUSH_IDLE: begin
          if (flush_go) begin
            state      <= FLUSH_ACTIVE;
            flush_pend <= 1'b0;
            flush_cnt  <= WADDR_WIDTH'(1);
          end else if (flush_want) begin
            flush_pend <= 1'b1;
          end
        end
        FLUSH_ACTIVE: begin
          if (flush_cnt == FLUSH_LAST) begin
            state     <= FLUSH_IDLE;
            flush_cnt <= '0;
          end else begin
            flush_cnt <= flush_cnt + 1'b1;
          end
        end
        default: state <= FLUSH_IDLE;
      endcase
    end
  end
`else
  assign flush_issue     = 1'b0;
  assign flush_block     = 1'b0;
  assign flush_addr      = '0;
  assign flush_busy_next = 1'b0;
`endif

  // Issue stage -> commit stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scm_we_o       <= 1'b0;
      scm_waddr_o    <= '0;
      scm_wway_o     <= '0;
      scm_wdata_o    <= '0;
      commit_valid_o <= 1'b0;
      commit_addr_o  <= '0;
      busy_o         <= 1'b0;
    end else begin
      scm_we_o <= flush_issue || (|gnt);
      if (flush_issue) begin
        scm_waddr_o <= flush_addr;
        scm_wway_o  <= WAY_ALL;
        scm_wdata_o <= '0;
      end else if (|gnt) begin
        scm_waddr_o <= sel_addr;
        scm_wway_o  <= sel_way;
        scm_wdata_o <= sel_data;
      end
      commit_valid_o <= scm_we_o;
      commit_addr_o  <= scm_waddr_o;
      busy_o         <= flush_issue || (|gnt) || scm_we_o || flush_busy_next;
    end
  end

endmodule

// File: tb/tb_scm_write_port_arbiter.sv
// Bench for scm_write_port_arbiter: directed scenarios plus randomized traffic
// against a cycle-level reference model; flush scenarios need SCM_ARB_FLUSH_EN.
module tb_scm_write_port_arbiter;

  localparam int N  = 3;
  localparam int AW = 5;
  localparam int WW = 4;
  localparam int DW = 64;

  logic                   clk;
  logic                   rst_n;
  logic [N-1:0]           req_valid;
  logic [N-1:0]           req_ready;
  logic [N-1:0][AW-1:0]   req_addr;
  logic [N-1:0][WW-1:0]   req_way;
  logic [N-1:0][DW-1:0]   req_data;
  logic                   scm_we;
  logic [AW-1:0]          scm_waddr;
  logic [WW-1:0]          scm_wway;
  logic [DW-1:0]          scm_wdata;
  logic                   commit_valid;
  logic [AW-1:0]          commit_addr;
  logic                   busy;
`ifdef SCM_ARB_FLUSH_EN
  logic                   flush_req;
  logic                   flush_busy;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  int            m_rr;
  logic          m_we, m_cv, m_busy;
  logic [AW-1:0] m_addr, m_caddr;
  logic [WW-1:0] m_way;
  logic [DW-1:0] m_data;

  scm_write_port_arbiter #(
    .NB_WAYS(WW), .WADDR_WIDTH(AW), .WDATA_WIDTH(DW), .N_REQ(N)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_addr_i    (req_addr),
    .req_way_i     (req_way),
    .req_data_i    (req_data),
    .scm_we_o      (scm_we),
    .scm_waddr_o   (scm_waddr),
    .scm_wway_o    (scm_wway),
    .scm_wdata_o   (scm_wdata),
    .commit_valid_o(commit_valid),
    .commit_addr_o (commit_addr),
    .busy_o        (busy)
`ifdef SCM_ARB_FLUSH_EN
    ,
    .flush_req_i   (flush_req),
    .flush_busy_o  (flush_busy)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_rr = 0; m_we = 0; m_cv = 0; m_busy = 0;
    m_addr = '0; m_caddr = '0; m_way = '0; m_data = '0;
  endtask

  // First valid requester at or after the pointer whose way does not clash with
  // a write issued in the immediately preceding slot.
  function automatic int model_pick(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_rr + k) % N;
      if (v[i] && !(m_we && (req_way[i] != m_way))) return i;
    end
    return -1;
  endfunction

  task automatic model_advance(input int g);
    m_cv    = m_we;
    m_caddr = m_addr;
    m_busy  = (g >= 0) || m_we;
    m_we    = (g >= 0);
    if (g >= 0) begin
      m_addr = req_addr[g];
      m_way  = req_way[g];
      m_data = req_data[g];
      m_rr   = (g + 1) % N;
    end
  endtask

  task automatic do_reset();
    req_valid = '0;
`ifdef SCM_ARB_FLUSH_EN
    flush_req = 1'b0;
`endif
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    req_valid = '0; req_addr = '0; req_way = '0; req_data = '0;
`ifdef SCM_ARB_FLUSH_EN
    flush_req = 1'b0;
`endif
    rst_n = 1'b0;
    #12;
    n_cmp++;
    if ({scm_we, scm_waddr, scm_wway, scm_wdata, commit_valid, commit_addr, busy} !== '0) begin
      n_err++; $display("FAIL reset_outputs: got we=%b addr=%h way=%b cv=%b busy=%b, want all 0",
                        scm_we, scm_waddr, scm_wway, commit_valid, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    req_way[1] = 4'b0001; req_way[2] = 4'b0001;
    req_valid = 3'b110;
    #1;
    n_cmp++;
    if (req_ready !== 3'b010) begin
      n_err++; $display("FAIL reset_rr_ptr: got ready=%b want %b", req_ready, 3'b010);
    end
    req_valid = '0;
  endtask

  task automatic test_single_write();
    do_reset();
    req_addr[0] = 5'd5; req_way[0] = 4'b0010; req_data[0] = 64'hDEAD_BEEF_0000_0001;
    req_valid = 3'b001;
    #1;
    n_cmp++;
    if (req_ready !== 3'b001) begin
      n_err++; $display("FAIL single_ready: got %b want %b", req_ready, 3'b001);
    end
    @(negedge clk);
    req_valid = '0;
    n_cmp++;
    if ({scm_we, scm_waddr, scm_wway, scm_wdata} !== {1'b1, 5'd5, 4'b0010, 64'hDEAD_BEEF_0000_0001}) begin
      n_err++; $display("FAIL single_issue: got we=%b addr=%0d way=%b data=%h want 1/5/0010/deadbeef00000001",
                        scm_we, scm_waddr, scm_wway, scm_wdata);
    end
    n_cmp++;
    if ({commit_valid, busy} !== 2'b01) begin
      n_err++; $display("FAIL single_busy1: got cv=%b busy=%b want cv=0 busy=1", commit_valid, busy);
    end
    @(negedge clk);
    n_cmp++;
    if ({scm_we, scm_wway, commit_valid, commit_addr, busy} !== {1'b0, 4'b0010, 1'b1, 5'd5, 1'b1}) begin
      n_err++; $display("FAIL single_commit: got we=%b way=%b cv=%b caddr=%0d busy=%b want 0/0010/1/5/1",
                        scm_we, scm_wway, commit_valid, commit_addr, busy);
    end
    @(negedge clk);
    n_cmp++;
    if ({commit_valid, busy} !== 2'b00) begin
      n_err++; $display("FAIL single_idle: got cv=%b busy=%b want 0/0", commit_valid, busy);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < N; i++) begin
      req_addr[i] = AW'(10 + i); req_way[i] = 4'b0001; req_data[i] = DW'(i);
    end
    req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      logic [N-1:0] exp_rdy;
      exp_rdy = N'(1 << (k % 3));
      #1;
      n_cmp++;
      if (req_ready !== exp_rdy) begin
        n_err++; $display("FAIL rr_grant[%0d]: got %b want %b", k, req_ready, exp_rdy);
      end
      @(negedge clk);
      n_cmp++;
      if ({scm_we, scm_waddr} !== {1'b1, AW'(10 + (k % 3))}) begin
        n_err++; $display("FAIL rr_issue[%0d]: got we=%b addr=%0d want 1/%0d", k, scm_we, scm_waddr, 10 + (k % 3));
      end
    end
    req_valid = '0;
  endtask

  task automatic test_way_hazard();
    do_reset();
    req_addr[0] = 5'd1; req_way[0] = 4'b0001; req_data[0] = 64'h11;
    req_addr[1] = 5'd2; req_way[1] = 4'b0010; req_data[1] = 64'h22;
    req_valid = 3'b001;
    #1;
    n_cmp++;
    if (req_ready !== 3'b001) begin
      n_err++; $display("FAIL haz_first_ready: got %b want %b", req_ready, 3'b001);
    end
    @(negedge clk);
    req_valid = 3'b010;
    #1;
    n_cmp++;
    if ({req_ready, scm_we, scm_wway} !== {3'b000, 1'b1, 4'b0001}) begin
      n_err++; $display("FAIL haz_blocked: got ready=%b we=%b way=%b want 000/1/0001", req_ready, scm_we, scm_wway);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if ({req_ready, scm_we, scm_wway} !== {3'b010, 1'b0, 4'b0001}) begin
      n_err++; $display("FAIL haz_bubble: got ready=%b we=%b way=%b want 010/0/0001", req_ready, scm_we, scm_wway);
    end
    @(negedge clk);
    req_valid = '0;
    n_cmp++;
    if ({scm_we, scm_waddr, scm_wway} !== {1'b1, 5'd2, 4'b0010}) begin
      n_err++; $display("FAIL haz_second: got we=%b addr=%0d way=%b want 1/2/0010", scm_we, scm_waddr, scm_wway);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] vld;
    do_reset();
    vld = '0;
    for (int c = 0; c < 400; c++) begin
      int g;
      logic [N-1:0] exp_rdy;
      for (int i = 0; i < N; i++) begin
        if (!vld[i] && ($urandom_range(0, 1) == 1)) begin
          req_addr[i] = AW'($urandom);
          case ($urandom_range(0, 3))
            0:       req_way[i] = 4'b0001;
            1:       req_way[i] = 4'b0010;
            2:       req_way[i] = 4'b1111;
            default: req_way[i] = WW'($urandom_range(1, 15));
          endcase
          req_data[i] = {$urandom, $urandom};
          vld[i] = 1'b1;
        end
      end
      req_valid = vld;
      #1;
      g = model_pick(vld);
      exp_rdy = (g >= 0) ? N'(1 << g) : '0;
      n_cmp++;
      if (req_ready !== exp_rdy) begin
        n_err++; $display("FAIL rand_ready[%0d]: got %b want %b", c, req_ready, exp_rdy);
      end
      model_advance(g);
      if (g >= 0) vld[g] = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({scm_we, scm_waddr, scm_wway, scm_wdata} !== {m_we, m_addr, m_way, m_data}) begin
        n_err++; $display("FAIL rand_issue[%0d]: got we=%b addr=%h way=%b data=%h want we=%b addr=%h way=%b data=%h",
                          c, scm_we, scm_waddr, scm_wway, scm_wdata, m_we, m_addr, m_way, m_data);
      end
      n_cmp++;
      if ({commit_valid, commit_addr, busy} !== {m_cv, m_caddr, m_busy}) begin
        n_err++; $display("FAIL rand_commit[%0d]: got cv=%b caddr=%h busy=%b want cv=%b caddr=%h busy=%b",
                          c, commit_valid, commit_addr, busy, m_cv, m_caddr, m_busy);
      end
    end
    // asynchronous reset while a write is in flight
    req_valid = 3'b001; req_way[0] = m_way;
    @(negedge clk);
    req_valid = '0;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({scm_we, scm_waddr, scm_wway, scm_wdata, commit_valid, commit_addr, busy} !== '0) begin
      n_err++; $display("FAIL midop_reset: got we=%b addr=%h way=%b cv=%b busy=%b want all 0",
                        scm_we, scm_waddr, scm_wway, commit_valid, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

`ifdef SCM_ARB_FLUSH_EN
  task automatic test_flush();
    do_reset();
    req_addr[1] = 5'd7; req_way[1] = 4'b1111; req_data[1] = 64'h1234;
    req_valid = 3'b010;
    flush_req = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 3'b000) begin
      n_err++; $display("FAIL flush_pending_ready: got %b want 000", req_ready);
    end
    @(negedge clk);
    flush_req = 1'b0;
    for (int a = 0; a < 32; a++) begin
      logic [N-1:0] exp_rdy;
      n_cmp++;
      if ({scm_we, scm_waddr, scm_wway, scm_wdata, flush_busy} !== {1'b1, AW'(a), 4'b1111, 64'd0, 1'b1}) begin
        n_err++; $display("FAIL flush_write[%0d]: got we=%b addr=%0d way=%b data=%h fbusy=%b want 1/%0d/1111/0/1",
                          a, scm_we, scm_waddr, scm_wway, scm_wdata, flush_busy, a);
      end
      exp_rdy = (a == 31) ? 3'b010 : 3'b000;
      #1;
      n_cmp++;
      if (req_ready !== exp_rdy) begin
        n_err++; $display("FAIL flush_ready[%0d]: got %b want %b", a, req_ready, exp_rdy);
      end
      @(negedge clk);
    end
    req_valid = '0;
    n_cmp++;
    if ({scm_we, scm_waddr, scm_wdata, commit_valid, commit_addr, flush_busy} !== {1'b1, 5'd7, 64'h1234, 1'b1, 5'd31, 1'b1}) begin
      n_err++; $display("FAIL flush_after: got we=%b addr=%0d data=%h cv=%b caddr=%0d fbusy=%b want 1/7/1234/1/31/1",
                        scm_we, scm_waddr, scm_wdata, commit_valid, commit_addr, flush_busy);
    end
    @(negedge clk);
    n_cmp++;
    if ({scm_we, flush_busy} !== 2'b00) begin
      n_err++; $display("FAIL flush_done: got we=%b fbusy=%b want 0/0", scm_we, flush_busy);
    end
  endtask

  task automatic test_reset_mid_flush();
    int cyc;
    do_reset();
    flush_req = 1'b1;
    @(negedge clk);
    flush_req = 1'b0;
    cyc = 0;
    while (scm_waddr != 5'd10 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    n_cmp++;
    if (scm_waddr !== 5'd10) begin
      n_err++; $display("FAIL flush_reach10: got addr=%0d want 10 within 100 cycles", scm_waddr);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({scm_we, scm_waddr, scm_wway, scm_wdata, commit_valid, commit_addr, busy, flush_busy} !== '0) begin
      n_err++; $display("FAIL flush_reset_outputs: got we=%b addr=%0d way=%b cv=%b busy=%b fbusy=%b want all 0",
                        scm_we, scm_waddr, scm_wway, commit_valid, busy, flush_busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    req_addr[0] = 5'd3; req_way[0] = 4'b0001; req_data[0] = 64'h5;
    req_valid = 3'b001;
    #1;
    n_cmp++;
    if (req_ready !== 3'b001) begin
      n_err++; $display("FAIL flush_reset_idle: got ready=%b want 001", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    flush_req = 1'b1;
    #1;
    n_cmp++;
    if ({req_ready, scm_we} !== {3'b000, 1'b1}) begin
      n_err++; $display("FAIL flush_restart_pend: got ready=%b we=%b want 000/1", req_ready, scm_we);
    end
    @(negedge clk);
    flush_req = 1'b0;
    n_cmp++;
    if ({scm_we, scm_wway} !== {1'b0, 4'b0001}) begin
      n_err++; $display("FAIL flush_restart_bubble: got we=%b way=%b want 0/0001", scm_we, scm_wway);
    end
    @(negedge clk);
    n_cmp++;
    if ({scm_we, scm_waddr, scm_wway} !== {1'b1, 5'd0, 4'b1111}) begin
      n_err++; $display("FAIL flush_restart_addr0: got we=%b addr=%0d way=%b want 1/0/1111", scm_we, scm_waddr, scm_wway);
    end
    repeat (40) @(negedge clk);
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    model_reset();
    test_reset();
    test_single_write();
    test_round_robin();
    test_way_hazard();
    test_random();
`ifdef SCM_ARB_FLUSH_EN
    test_flush();
    test_reset_mid_flush();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
